buffer_128_to_512: RTL and testbench

BUFFER_128_TO_512 -- requirements
Module: buffer_128_to_512

---
 rtl/buffer_128_to_512.sv | 108 ++++++++++
 tb/tb_buffer_128_to_512.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/buffer_128_to_512.sv
// Packs four 128-bit writes into one 512-bit entry and queues entries in a
// DEPTH-deep first-word fall-through store.
module buffer_128_to_512 #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [127:0]  data_in,
    input  logic          wr_enable,
    output logic [511:0]  data_out,
    input  logic          rd_enable,
    output logic          full,
    output logic          empty,
    output logic          full_n,
    output logic [1:0]    lane,
    output logic [AW:0]   level
);

    localparam int unsigned WW = 128;
    localparam int unsigned EW = 512;
    localparam int unsigned LW = AW + 1;

    logic [1:0]      lane_q, lane_d;
    logic [LW-1:0]   level_q, level_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [3*WW-1:0] asm_q, asm_d;
    logic [EW-1:0]   mem_q [DEPTH];

    logic wr_accept_c;
    logic push_c;
    logic pop_c;

    // Status flags come straight from registered state.
    assign full   = (level_q == LW'(DEPTH)) && (lane_q == 2'd3);
    assign empty  = (level_q == '0);
    assign full_n = (level_q >= LW'(DEPTH - 1));
    assign lane   = lane_q;
    assign level  = level_q;

    assign wr_accept_c = wr_enable && !full;
    assign push_c      = wr_accept_c && (lane_q == 2'd3);
    assign pop_c       = rd_enable && !empty;

    assign data_out = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        lane_d   = lane_q;
        level_d  = level_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        asm_d    = asm_q;
        if (clr) begin
            lane_d   = '0;
            level_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            asm_d    = '0;
        end else begin
            if (wr_accept_c) begin
                lane_d = lane_q + 2'd1;
                case (lane_q)
                    2'd0:    asm_d[WW-1:0]      = data_in;
                    2'd1:    asm_d[2*WW-1:WW]   = data_in;
                    2'd2:    asm_d[3*WW-1:2*WW] = data_in;
                    default: asm_d              = asm_q;
                endcase
            end
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_q   <= '0;
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            asm_q    <= '0;
        end else begin
            lane_q   <= lane_d;
            level_q  <= level_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            asm_q    <= asm_d;
        end
    end

    // Entry storage carries no reset; validity is tracked by level_q alone.
    always_ff @(posedge clk) begin
        if (push_c && !clr) begin
            mem_q[wr_ptr_q] <= {data_in, asm_q};
        end
    end

endmodule

// File: tb/tb_buffer_128_to_512.sv
// Directed and randomized-order checks for buffer_128_to_512 at DEPTH=4.
module tb_buffer_128_to_512;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic [127:0] data_in;
    logic         wr_enable;
    logic         rd_enable;
    logic [511:0] data_out;
    logic         full, empty, full_n;
    logic [1:0]   lane;
    logic [AW:0]  level;

    int n_tests = 0;
    int n_fail  = 0;

    logic [511:0] q [$];

    buffer_128_to_512 #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .clr(clr), .data_in(data_in),
        .wr_enable(wr_enable), .data_out(data_out), .rd_enable(rd_enable),
        .full(full), .empty(empty), .full_n(full_n), .lane(lane), .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] w(input int i);
        return {32'(i), 32'hCAFE0000, 32'(i) ^ 32'h0000FFFF, 32'(i)};
    endfunction

    function automatic logic [511:0] entry(input int b);
        return {w(b + 3), w(b + 2), w(b + 1), w(b)};
    endfunction

    // One clock with the given inputs; returns #1 after the rising edge.
    task automatic step(input logic wr, input logic rd, input logic c, input logic [127:0] d);
        wr_enable = wr;
        rd_enable = rd;
        clr       = c;
        data_in   = d;
        @(posedge clk);
        #1;
        wr_enable = 1'b0;
        rd_enable = 1'b0;
        clr       = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_empty"}, 512'(empty), 512'd1);
        check({tag, "_full"}, 512'(full), 512'd0);
        check({tag, "_full_n"}, 512'(full_n), 512'd0);
        check({tag, "_lane"}, 512'(lane), 512'd0);
        check({tag, "_level"}, 512'(level), 512'd0);
        check({tag, "_data"}, data_out, 512'd0);
    endtask

    initial begin
        int           pushed;
        int           cyc;
        int           wcnt;
        int           m_lane;
        logic         m_full;
        logic         wr_b, rd_b;
        logic [383:0] part;

        rst = 1'b0; clr = 1'b0; wr_enable = 1'b0; rd_enable = 1'b0; data_in = '0;
        #1;
        check_reset_outputs("reset");
        #11;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic pack of four words.
        step(1, 0, 0, 128'h1);
        step(1, 0, 0, 128'h2);
        check("pack_lane2", 512'(lane), 512'd2);
        check("pack_empty_partial", 512'(empty), 512'd1);
        step(1, 0, 0, 128'h3);
        step(1, 0, 0, 128'h4);
        check("pack_empty", 512'(empty), 512'd0);
        check("pack_level", 512'(level), 512'd1);
        check("pack_lane0", 512'(lane), 512'd0);
        check("pack_data", data_out, {128'h4, 128'h3, 128'h2, 128'h1});
        step(0, 1, 0, '0);
        check("pack_pop_empty", 512'(empty), 512'd1);
        check("pack_pop_data", data_out, 512'd0);
        step(0, 1, 0, '0);
        check("pop_when_empty_level", 512'(level), 512'd0);

        // Fill to capacity.
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0, w(100 + i));
            if (i == 7)  check("fill_level2_full_n", 512'({level, full_n}), 512'({3'd2, 1'b0}));
            if (i == 11) check("fill_level3_full_n", 512'({level, full_n}), 512'({3'd3, 1'b1}));
        end
        check("fill_level4", 512'(level), 512'd4);
        check("fill_full_lane0", 512'(full), 512'd0);
        for (int i = 16; i < 19; i++) step(1, 0, 0, w(100 + i));
        check("fill_lane3", 512'(lane), 512'd3);
        check("fill_full", 512'(full), 512'd1);
        step(1, 0, 0, w(999));
        check("fill_ignored_lane", 512'(lane), 512'd3);
        check("fill_ignored_level", 512'(level), 512'd4);
        check("fill_head", data_out, entry(100));

        // Read and write together while full: pop wins, write rejected.
        step(1, 1, 0, w(998));
        check("full_rw_level", 512'(level), 512'd3);
        check("full_rw_full", 512'(full), 512'd0);
        check("full_rw_lane", 512'(lane), 512'd3);
        step(1, 0, 0, w(119));
        check("full_rw_retry_level", 512'(level), 512'd4);
        check("full_rw_retry_lane", 512'(lane), 512'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain_%0d", k), data_out, entry(104 + 4 * k));
            step(0, 1, 0, '0);
        end
        check("drain_empty", 512'(empty), 512'd1);

        // Partial assembly discarded by clr, which beats wr_enable.
        step(1, 0, 0, w(30));
        step(1, 0, 0, w(31));
        check("clr_pre_lane", 512'(lane), 512'd2);
        step(1, 0, 1, w(32));
        check("clr_lane", 512'(lane), 512'd0);
        check("clr_level", 512'(level), 512'd0);
        check("clr_empty", 512'(empty), 512'd1);
        for (int i = 0; i < 4; i++) step(1, 0, 0, w(40 + i));
        check("clr_clean_entry", data_out, entry(40));
        check("clr_clean_level", 512'(level), 512'd1);
        step(0, 1, 0, '0);

        // Asynchronous reset mid-stream, between clock edges.
        for (int i = 0; i < 9; i++) step(1, 0, 0, w(60 + i));
        check("arst_pre_level", 512'(level), 512'd2);
        check("arst_pre_lane", 512'(lane), 512'd1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("arst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("arst_resume_level", 512'(level), 512'd0);

        // Random interleaving against a reference queue.
        q.delete();
        pushed = 0; cyc = 0; wcnt = 200; m_lane = 0; part = '0;
        while ((pushed < 3 * DEPTH || q.size() > 0) && cyc < 2000) begin
            wr_b   = (pushed < 3 * DEPTH) ? 1'($urandom_range(0, 1)) : 1'b0;
            rd_b   = ($urandom_range(0, 3) == 0);
            m_full = (q.size() == DEPTH) && (m_lane == 3);
            if (q.size() > 0) check("rand_head", data_out, q[0]);
            else              check("rand_empty", 512'(empty), 512'd1);
            check("rand_full", 512'(full), 512'(m_full));
            step(wr_b, rd_b, 0, w(wcnt));
            if (rd_b && q.size() > 0) void'(q.pop_front());
            if (wr_b && !m_full) begin
                if (m_lane == 3) begin
                    q.push_back({w(wcnt), part});
                    pushed++;
                    m_lane = 0;
                end else begin
                    part[m_lane * 128 +: 128] = w(wcnt);
                    m_lane++;
                end
                wcnt++;
            end
            check("rand_level", 512'(level), 512'(q.size()));
            check("rand_lane", 512'(lane), 512'(m_lane));
            cyc++;
        end
        check("rand_timeout", 512'(cyc < 2000), 512'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
